// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file port arbiter.
package rf_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam int RF_DATA_W = 13;
  localparam int RF_ADDR_W = 7;
  localparam int RF_DEPTH  = 16;

  // Index width for n items; never below 1 so single-entry vectors stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rf_bank_1w1r.sv
// One-write/one-read register file bank; a same-cycle write to the read
// address is forwarded to the read output. Storage is not reset.
module rf_bank_1w1r #(
  parameter int DATA_W = 13,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata = mem_q[raddr];
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one 1W/1R register file bank among NREQ requesters.
// Optional macro RF_ARB_PRIO0_EN gives requester 0 fixed top priority.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   init_done
);

  localparam int IDX_W   = clog2(NREQ);
  localparam int BANK_AW = clog2(DEPTH);
  localparam logic [BANK_AW-1:0] LAST_ENTRY = BANK_AW'(DEPTH - 1);
  localparam logic [IDX_W-1:0]   PTR_RST    = IDX_W'(NREQ - 1);
`ifdef RF_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [BANK_AW-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                init_done_q, init_done_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                gnt_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    cand;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic                g_we;
  logic                g_oor;

  logic                bank_we;
  logic [BANK_AW-1:0]  bank_waddr;
  logic [DATA_W-1:0]   bank_wdata;
  logic [BANK_AW-1:0]  bank_raddr;
  logic [DATA_W-1:0]   bank_rdata;

  // Arbitration: search begins one past the last round-robin winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (init_done_q) begin
      if (PRIO0 && req_valid[0]) gnt_any = 1'b1;
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDX_W'((int'(ptr_q) + k) % NREQ);
        if (!gnt_any && req_valid[cand] && !(PRIO0 && (cand == '0))) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    g_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    g_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
    g_we    = req_we[gnt_idx];
    g_oor   = (int'(g_addr) >= DEPTH);
  end

  // FSM, bank port steering and response register next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    init_done_d = (state_q == ST_RUN);
    bank_we     = 1'b0;
    bank_waddr  = g_addr[BANK_AW-1:0];
    bank_wdata  = g_wdata;
    bank_raddr  = g_addr[BANK_AW-1:0];
    rsp_valid_d = req_ready;
    rsp_err_d   = gnt_any & g_oor;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_INIT: begin
        bank_we    = 1'b1;
        bank_waddr = cnt_q;
        bank_wdata = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_ENTRY) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (gnt_any && g_we && !g_oor) bank_we = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase

    if (gnt_any) begin
      if (!(PRIO0 && (gnt_idx == '0))) ptr_d = gnt_idx;
      if (g_we)       rsp_data_d = g_wdata;
      else if (g_oor) rsp_data_d = '0;
      else            rsp_data_d = bank_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= PTR_RST;
      init_done_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  rf_bank_1w1r #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (BANK_AW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (bank_raddr),
    .rdata (bank_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter; the RF_ARB_PRIO0_EN build switches the
// two-requester arbitration expectations.
module tb_rf_port_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 13;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;
  logic                   init_done;

  int checks = 0;
  int errors = 0;

  rf_port_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic set_req(input int r, input logic we, input int addr, input int wd);
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    req_wdata[r*DATA_W +: DATA_W] = DATA_W'(wd);
  endtask

  task automatic xfer(input string tag, input int r, input logic we, input int addr,
                      input int wd, input int exp_d, input int exp_e);
    clr();
    set_req(r, we, addr, wd);
    #1;
    chk({tag, "_rdy"}, int'(req_ready), 1 << r);
    tick();
    chk({tag, "_vld"}, int'(rsp_valid), 1 << r);
    chk({tag, "_dat"}, int'(rsp_data), exp_d);
    chk({tag, "_err"}, int'(rsp_err), exp_e);
    clr();
  endtask

  task automatic init_wait();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0);
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      chk("init_rdy", int'(req_ready), 0);
      chk("init_done_low", int'(init_done), 0);
    end
    clr();
    tick();
    chk("init_done_rise", int'(init_done), 1);
    chk("idle_rdy", int'(req_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int rr_seq [5];
    rr_seq = '{0, 1, 2, 3, 0};
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_init_done", int'(init_done), 0);
    reset = 1'b0;
    init_wait();

    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3, 0);
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("rr_rdy", int'(req_ready), 1 << rr_seq[j]);
      tick();
      chk("rr_vld", int'(rsp_valid), 1 << rr_seq[j]);
      chk("rr_dat", int'(rsp_data), 0);
    end
    clr();

    for (int a = 0; a < DEPTH; a++) xfer("clr_rd", a % NREQ, 1'b0, a, 0, 0, 0);

    xfer("wr5",   1, 1'b1, 5,  'h1ABC, 'h1ABC, 0);
    xfer("rd5",   2, 1'b0, 5,  0,      'h1ABC, 0);
    xfer("wr15",  3, 1'b1, 15, 'h0555, 'h0555, 0);
    xfer("wr0",   0, 1'b1, 0,  'h1F0F, 'h1F0F, 0);
    xfer("rd15",  1, 1'b0, 15, 0,      'h0555, 0);
    xfer("rd0",   3, 1'b0, 0,  0,      'h1F0F, 0);
    xfer("rd6",   2, 1'b0, 6,  0,      0,      0);
    xfer("wr20",  0, 1'b1, 20, 'h0FFF, 'h0FFF, 1);
    xfer("rd20",  1, 1'b0, 20, 0,      0,      1);
    xfer("rd4",   2, 1'b0, 4,  0,      0,      0);
    xfer("rd16",  3, 1'b0, 16, 0,      0,      1);
    xfer("rd127", 0, 1'b0, 127, 0,     0,      1);
    xfer("rd5b",  1, 1'b0, 5,  0,      'h1ABC, 0);

    tick();
    chk("hold_vld", int'(rsp_valid), 0);
    chk("hold_dat", int'(rsp_data), 'h1ABC);
    chk("hold_err", int'(rsp_err), 0);

    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5, 0);
    #1;
    chk("burst_rdy", int'(req_ready), 'h4);
    tick();
    chk("burst_vld", int'(rsp_valid), 'h4);
    chk("burst_dat", int'(rsp_data), 'h1ABC);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", int'(rsp_valid), 0);
    chk("mid_rst_rdy", int'(req_ready), 0);
    chk("mid_rst_done", int'(init_done), 0);
    chk("mid_rst_dat", int'(rsp_data), 0);
    #1;
    reset = 1'b0;
    init_wait();

    set_req(0, 1'b0, 1, 0);
    set_req(2, 1'b0, 2, 0);
`ifdef RF_ARB_PRIO0_EN
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("prio_rdy", int'(req_ready), 'h1);
      tick();
      chk("prio_vld", int'(rsp_valid), 'h1);
    end
    req_valid[0] = 1'b0;
    #1;
    chk("prio_drop_rdy", int'(req_ready), 'h4);
    tick();
    chk("prio_drop_vld", int'(rsp_valid), 'h4);
`else
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("rr2_rdy", int'(req_ready), (j % 2 == 0) ? 'h1 : 'h4);
      tick();
      chk("rr2_vld", int'(rsp_valid), (j % 2 == 0) ? 'h1 : 'h4);
    end
`endif
    clr();

    xfer("post_rd5",  0, 1'b0, 5,  0, 0, 0);
    xfer("post_rd15", 1, 1'b0, 15, 0, 0, 0);
    xfer("post_rd0",  3, 1'b0, 0,  0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
